serial_pattern_shifter: RTL and testbench
=========================================

Name: serial_pattern_shifter

Overview:
- Upstream stimulus stage for the Mealy zero detector. Accepts a parallel bit pattern over a valid/ready handshake and serialises it MSB-first onto a single-bit line (x_out), which drives the detector's x_in.
- Each bit is held for a programmable number of clock cycles.
- Supports gapless back-to-back frames, pattern repeat and pause.

Parameters:
- WIDTH, 8, pattern length in bits (2..32).
- DIV, 1, clock cycles per serial bit (1..65535).
- IDLE_LEVEL, 1'b0, x_out value when no frame is active.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  shifter can accept a pattern this cycle.
- load_data  in  WIDTH  pattern; bit WIDTH-1 is sent first.
- repeat_en  in  1  at frame end, resend the same pattern instead of finishing.
- hold  in  1  freezes shifting; x_out keeps its current bit.
- x_out  out  1  serial bit stream (to detector x_in).
- x_valid  out  1  x_out carries a pattern bit.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse in the last cycle of a frame's last bit.

Behaviour:
- Reset (sync, priority over everything, including mid-frame):
  - state=IDLE, x_out=IDLE_LEVEL, x_valid=0, busy=0, frame_done=0.
  - Shift, copy, bit and divider registers are cleared.
  - load_ready=1 from the first cycle after reset deasserts.
- All outputs except load_ready are registered. load_ready is combinational from state, counters, hold and repeat_en only; it never depends on load_valid.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1.
  - Accept = load_valid & load_ready at edge T.
  - On accept: capture load_data into the shift register and the copy register, bit_cnt=0, div_cnt=0, go to SHIFT.
- SHIFT timing:
  - From cycle T+1: x_valid=1, busy=1, x_out=load_data[WIDTH-1].
  - Bit i (i=0 is the MSB) occupies cycles T+1+i*DIV .. T+(i+1)*DIV.
  - Frame latency is WIDTH*DIV cycles.
- SHIFT counters:
  - div_cnt counts 0..DIV-1.
  - At div_cnt==DIV-1 with hold=0: shift left, bit_cnt++, div_cnt=0.
  - With DIV=1 the shift happens every cycle.
- hold=1 in SHIFT:
  - div_cnt and bit_cnt are frozen; x_out and x_valid are unchanged.
  - frame_done and load_ready are suppressed.
  - hold is ignored in IDLE.
- Last cycle of a frame (bit_cnt==WIDTH-1, div_cnt==DIV-1, hold=0):
  - frame_done=1 for exactly this cycle. It is generated from a registered look-ahead so it aligns with the last bit.
  - repeat_en=1: reload the shift register from the copy register and continue in SHIFT with no gap. load_ready=0 and load_valid is ignored.
  - repeat_en=0: load_ready=1.
    - If load_valid=1, the new pattern is captured and its MSB appears the next cycle (gapless, busy stays 1).
    - Otherwise go to IDLE: next cycle x_out=IDLE_LEVEL, x_valid=0, busy=0.
- load_ready=0 during SHIFT except in the frame-end case above. A load_valid while not ready is ignored; there is no buffering.
- repeat_en is sampled only in the last cycle of a frame. Toggling it mid-frame has no effect.
- Counter widths: bit_cnt is $clog2(WIDTH) bits and div_cnt is $clog2(DIV+1) bits. Neither counter ever exceeds its terminal value.

Decomposition:
- Shared package pattern_pkg:
  - state enum {IDLE, SHIFT} (1 bit).
  - Default WIDTH/DIV constants.
  - Helper function for the counter width.
- One sub-module: bit_tick_gen (the divider). Inputs: clock, reset, clear, hold. Output: tick, high in the last cycle of each bit period.
- Shift, copy and FSM logic stay in the top module.

Test Plan:
1. Reset and idle: assert reset for 2 cycles mid-frame (WIDTH=8, DIV=1, pattern 8'hF0) -> the next cycle shows x_out=0, x_valid=0, busy=0, load_ready=1; the partial frame is discarded.
2. Single frame: DIV=1, load 8'b1110_0100 at T, repeat_en=0 -> x_out over T+1..T+8 = 1,1,1,0,0,1,0,0; frame_done only at T+8; x_valid=0 at T+9.
3. Divider: DIV=3, load 8'hA5 -> each bit held exactly 3 cycles (24-cycle frame); frame_done at T+24.
4. Back-to-back: hold load_valid=1 with 8'hFF then 8'h00 -> second frame's MSB at T+9; x_valid and busy never drop between frames.
5. Repeat: repeat_en=1, pattern 8'h81 -> stream 1,0,0,0,0,0,0,1,1,0,... with no gap; frame_done every 8 cycles; load_ready stays 0.
6. Hold: DIV=2, assert hold for 5 cycles during bit 3 -> bit 3 lasts 7 cycles; frame_done delayed by 5 cycles; no frame_done or load_ready while hold=1.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and sizing helpers for the serial pattern shifter and its divider.
package pattern_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 1;

    // Counter width that holds values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts DIV clock cycles per serial bit and flags the last one.
module bit_tick_gen
    import pattern_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
)
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int            DW       = cnt_width(DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_next;
    logic          last_q;

    always_comb begin
        div_cnt_next = div_cnt;
        if (clear) begin
            div_cnt_next = '0;
        end else if (!hold) begin
            div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    // last_q is a registered look-ahead of "counter sits on its terminal value".
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            last_q  <= (DIV_LAST == '0);
        end else begin
            div_cnt <= div_cnt_next;
            last_q  <= (div_cnt_next == DIV_LAST);
        end
    end

    assign tick = last_q & ~hold;

endmodule

// File: rtl/serial_pattern_shifter.sv
// Serialises a parallel pattern MSB-first onto x_out, DIV cycles per bit,
// with gapless reload, repeat and hold.
module serial_pattern_shifter
    import pattern_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter int   DIV        = DEFAULT_DIV,
    parameter logic IDLE_LEVEL = 1'b0
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             repeat_en,
    input  logic             hold,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int            BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] copy_reg;
    logic [WIDTH-1:0] copy_next;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_next;
    logic             bit_last_q;
    logic             tick;
    logic             tick_clear;
    logic             frame_end;
    logic             accept;
    logic             x_out_next;
    logic             x_valid_next;

    assign tick_clear = (state == IDLE);

    bit_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(tick_clear),
        .hold (hold),
        .tick (tick)
    );

    // tick already carries ~hold, so a held last cycle is not a frame end.
    assign frame_end  = (state == SHIFT) & bit_last_q & tick;
    assign load_ready = (state == IDLE) | (frame_end & ~repeat_en);
    assign accept     = load_valid & load_ready;
    assign frame_done = frame_end;

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        copy_next    = copy_reg;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next   = load_data;
                    copy_next    = load_data;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_last_q) begin
                        bit_cnt_next = '0;
                        if (repeat_en) begin
                            shift_next = copy_reg;
                        end else if (accept) begin
                            shift_next = load_data;
                            copy_next  = load_data;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        shift_next   = shift_reg << 1;
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        x_valid_next = (state_next == SHIFT);
        x_out_next   = (state_next == SHIFT) ? shift_next[WIDTH-1] : IDLE_LEVEL;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            copy_reg   <= '0;
            bit_cnt    <= '0;
            bit_last_q <= 1'b0;
            x_out      <= IDLE_LEVEL;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            copy_reg   <= copy_next;
            bit_cnt    <= bit_cnt_next;
            bit_last_q <= (state_next == SHIFT) && (bit_cnt_next == LAST_BIT);
            x_out      <= x_out_next;
            x_valid    <= x_valid_next;
            busy       <= x_valid_next;
        end
    end

endmodule

// File: tb/tb_serial_pattern_shifter.sv
// Bench for serial_pattern_shifter: three instances (DIV=1,2,3) checked every cycle
// against a position-based frame model, plus directed literal expectations.
module tb_serial_pattern_shifter;

    logic       clock;
    logic       reset;
    logic [2:0] lv;
    logic [2:0] rep;
    logic [2:0] hd;
    logic [7:0] ld [3];
    logic [2:0] lr;
    logic [2:0] xo;
    logic [2:0] xv;
    logic [2:0] bz;
    logic [2:0] fd;

    int checks = 0;
    int errors = 0;

    serial_pattern_shifter #(.WIDTH(8), .DIV(1), .IDLE_LEVEL(1'b0)) u_d1 (
        .clock(clock), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]),
        .load_data(ld[0]), .repeat_en(rep[0]), .hold(hd[0]), .x_out(xo[0]),
        .x_valid(xv[0]), .busy(bz[0]), .frame_done(fd[0]));

    serial_pattern_shifter #(.WIDTH(8), .DIV(2), .IDLE_LEVEL(1'b0)) u_d2 (
        .clock(clock), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]),
        .load_data(ld[1]), .repeat_en(rep[1]), .hold(hd[1]), .x_out(xo[1]),
        .x_valid(xv[1]), .busy(bz[1]), .frame_done(fd[1]));

    serial_pattern_shifter #(.WIDTH(8), .DIV(3), .IDLE_LEVEL(1'b0)) u_d3 (
        .clock(clock), .reset(reset), .load_valid(lv[2]), .load_ready(lr[2]),
        .load_data(ld[2]), .repeat_en(rep[2]), .hold(hd[2]), .x_out(xo[2]),
        .x_valid(xv[2]), .busy(bz[2]), .frame_done(fd[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: a frame is a pattern plus the number of un-held cycles spent in it.
    logic       model_on = 1'b0;
    logic       m_active [3];
    logic [7:0] m_pat    [3];
    int         m_pos    [3];

    function automatic logic model_end(input int d);
        return m_active[d] && (m_pos[d] == 8 * (d + 1) - 1) && !hd[d];
    endfunction

    always @(posedge clock) begin
        if (reset) model_on <= 1'b1;
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_active[d] <= 1'b0;
                m_pos[d]    <= 0;
            end else if (!m_active[d]) begin
                if (lv[d]) begin
                    m_active[d] <= 1'b1;
                    m_pat[d]    <= ld[d];
                    m_pos[d]    <= 0;
                end
            end else if (!hd[d]) begin
                if (model_end(d)) begin
                    m_pos[d] <= 0;
                    if (!rep[d]) begin
                        if (lv[d]) m_pat[d]    <= ld[d];
                        else       m_active[d] <= 1'b0;
                    end
                end else begin
                    m_pos[d] <= m_pos[d] + 1;
                end
            end
        end
    end

    task automatic check_output(input string name, input int d,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual=%0h expected=%0h at %0t",
                     name, d, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_on) begin
            for (int d = 0; d < 3; d++) begin
                logic e_xo;
                logic e_end;
                e_end = model_end(d);
                e_xo  = m_active[d] ? m_pat[d][7 - m_pos[d] / (d + 1)] : 1'b0;
                check_output("x_out",      d, 32'(xo[d]), 32'(e_xo));
                check_output("x_valid",    d, 32'(xv[d]), 32'(m_active[d]));
                check_output("busy",       d, 32'(bz[d]), 32'(m_active[d]));
                check_output("frame_done", d, 32'(fd[d]), 32'(e_end));
                check_output("load_ready", d, 32'(lr[d]),
                             32'(!m_active[d] || (e_end && !rep[d])));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input int d, input logic v, input logic [7:0] data,
                                  input logic r, input logic h);
        lv[d]  = v;
        ld[d]  = data;
        rep[d] = r;
        hd[d]  = h;
    endtask

    initial begin
        logic [7:0]  bits8;
        logic [15:0] bits16;
        int          fd_at;
        int          fd_cnt;
        int          cnt_a;
        int          cnt_b;
        logic        s_a;
        logic        s_b;

        reset = 1'b1;
        for (int d = 0; d < 3; d++) apply_stimulus(d, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        $display("[TB] reset released");

        // Test 1: reset mid-frame discards the frame.
        apply_stimulus(0, 1'b1, 8'hF0, 1'b0, 1'b0);
        step();
        lv[0] = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        check_output("t1_x_out",      0, 32'(xo[0]), 32'd0);
        check_output("t1_x_valid",    0, 32'(xv[0]), 32'd0);
        check_output("t1_busy",       0, 32'(bz[0]), 32'd0);
        check_output("t1_load_ready", 0, 32'(lr[0]), 32'd1);
        step();
        step();
        step();
        @(negedge clock);
        check_output("t1_discard", 0, 32'(xv[0]), 32'd0);
        step();

        // Test 2: single frame, DIV=1.
        apply_stimulus(0, 1'b1, 8'b1110_0100, 1'b0, 1'b0);
        step();
        lv[0]  = 1'b0;
        fd_at  = 0;
        fd_cnt = 0;
        bits8  = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            bits8[8 - c] = xo[0];
            if (fd[0]) begin
                fd_cnt++;
                fd_at = c;
            end
            step();
        end
        @(negedge clock);
        check_output("t2_stream",  0, 32'(bits8), 32'hE4);
        check_output("t2_fd_at",   0, 32'(fd_at), 32'd8);
        check_output("t2_fd_cnt",  0, 32'(fd_cnt), 32'd1);
        check_output("t2_x_valid", 0, 32'(xv[0]), 32'd0);
        step();

        // Test 3: DIV=3, each bit held three cycles.
        apply_stimulus(2, 1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        lv[2] = 1'b0;
        fd_at = 0;
        s_a   = 1'b0;
        s_b   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 3) s_a = xo[2];
            if (c == 4) s_b = xo[2];
            if (fd[2] && fd_at == 0) fd_at = c;
            step();
        end
        @(negedge clock);
        check_output("t3_fd_at",   2, 32'(fd_at), 32'd24);
        check_output("t3_bit0_end", 2, 32'(s_a), 32'd1);
        check_output("t3_bit1_beg", 2, 32'(s_b), 32'd0);
        check_output("t3_idle",    2, 32'(xv[2]), 32'd0);
        step();

        // Test 4: back-to-back frames with load_valid held high.
        apply_stimulus(0, 1'b1, 8'hFF, 1'b0, 1'b0);
        step();
        ld[0] = 8'h00;
        cnt_a = 0;
        s_a   = 1'b0;
        s_b   = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            if (!xv[0] || !bz[0]) cnt_a++;
            if (c == 8) s_a = xo[0];
            if (c == 9) s_b = xo[0];
            step();
            if (c == 8) lv[0] = 1'b0;
        end
        check_output("t4_gap",     0, 32'(cnt_a), 32'd0);
        check_output("t4_last_ff", 0, 32'(s_a), 32'd1);
        check_output("t4_msb_00",  0, 32'(s_b), 32'd0);
        step();

        // Test 5: repeat with no gap.
        apply_stimulus(0, 1'b1, 8'h81, 1'b1, 1'b0);
        step();
        lv[0]  = 1'b0;
        fd_cnt = 0;
        cnt_a  = 0;
        bits16 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c <= 16) bits16[16 - c] = xo[0];
            if (fd[0]) fd_cnt++;
            if (lr[0]) cnt_a++;
            step();
        end
        check_output("t5_stream", 0, 32'(bits16), 32'h8181);
        check_output("t5_fd_cnt", 0, 32'(fd_cnt), 32'd2);
        check_output("t5_ready",  0, 32'(cnt_a), 32'd0);
        rep[0] = 1'b0;
        cnt_b  = 0;
        @(negedge clock);
        while (bz[0] && cnt_b < 40) begin
            step();
            cnt_b++;
            @(negedge clock);
        end
        check_output("t5_stop", 0, 32'(bz[0]), 32'd0);
        step();

        // Test 6: hold for five cycles during bit 3, DIV=2.
        apply_stimulus(1, 1'b1, 8'h10, 1'b0, 1'b0);
        step();
        lv[1] = 1'b0;
        fd_at = 0;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 1; c <= 30; c++) begin
            hd[1] = (c >= 7 && c <= 11);
            @(negedge clock);
            if (xo[1]) cnt_a++;
            if (fd[1] && fd_at == 0) fd_at = c;
            if (hd[1] && (fd[1] || lr[1])) cnt_b++;
            step();
        end
        hd[1] = 1'b0;
        check_output("t6_bit3_len",  1, 32'(cnt_a), 32'd7);
        check_output("t6_fd_at",     1, 32'(fd_at), 32'd21);
        check_output("t6_held_flag", 1, 32'(cnt_b), 32'd0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
